// File: rtl/loop_echo_if.sv
// loop_echo_if: strobe bus between the loopback responder and the link checker.
// slave = responder view, master = link-checker/driver view.
interface loop_echo_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
);
  logic              rx_stb_i;
  logic [DWIDTH-1:0] rx_data_i;
  logic              tx_ready_i;
  logic              tx_stb_o;
  logic [DWIDTH-1:0] tx_data_o;
  logic [AWIDTH:0]   count_o;
  logic              overflow_o;

  modport slave (
    input  rx_stb_i, rx_data_i, tx_ready_i,
    output tx_stb_o, tx_data_o, count_o, overflow_o
  );

  modport master (
    output rx_stb_i, rx_data_i, tx_ready_i,
    input  tx_stb_o, tx_data_o, count_o, overflow_o
  );
endinterface

// File: rtl/loop_echo.sv
// loop_echo: far-end loopback responder. Buffers strobed words in a FIFO and
// re-emits them in order as a strobe stream, with optional forced gap.
// Optional build macro LOOP_ECHO_INJECT_EN adds inj_i, which corrupts bit 0
// of the next popped word (one-shot).
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | may pop the head word when occupancy > 0 and tx_ready_i is high
// ST_GAP  | counting forced idle cycles after a strobe
module loop_echo #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int GAP    = 0
) (
  input  logic clk_i,
  input  logic rst_i,
`ifdef LOOP_ECHO_INJECT_EN
  input  logic inj_i,
`endif
  loop_echo_if.slave bus
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int GW    = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0]   GAP_L  = GAP[GW-1:0];
  localparam logic [AWIDTH:0] L_FULL = {1'b1, {AWIDTH{1'b0}}};

  typedef enum logic {ST_IDLE = 1'b0, ST_GAP = 1'b1} state_t;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_count;
  logic              r_overflow;
  logic              r_tx_stb;
  logic [DWIDTH-1:0] r_tx_data;
  logic [GW-1:0]     r_gap_cnt;
  state_t            r_state;

  state_t            w_state_nxt;
  logic [GW-1:0]     w_gap_nxt;
  logic              w_pop;
  logic              w_wr;
  logic              w_full;
  logic [DWIDTH-1:0] w_head;
  logic [DWIDTH-1:0] w_out_data;

  assign w_full = (r_count == L_FULL);
  // Full is judged on the pre-edge count, so a pop in the same cycle does not
  // make room for the incoming word.
  assign w_wr   = bus.rx_stb_i && !w_full;
  assign w_head = r_mem[r_rd_ptr];

`ifdef LOOP_ECHO_INJECT_EN
  logic r_inj;

  // One-shot corruption flag: armed by inj_i, consumed by the next pop.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_inj <= 1'b0;
    else if (w_pop)
      r_inj <= inj_i;
    else if (inj_i)
      r_inj <= 1'b1;
  end

  assign w_out_data = w_head ^ {{(DWIDTH-1){1'b0}}, r_inj};
`else
  assign w_out_data = w_head;
`endif

  // FIFO storage; written only when the word is accepted.
  always_ff @(posedge clk_i) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= bus.rx_data_i;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus.rx_stb_i && w_full)
        r_overflow <= 1'b1;
    end
  end

  // Read FSM state register and gap counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Read FSM next state: pop decision in IDLE, gap countdown in GAP.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((r_count != '0) && bus.tx_ready_i) begin
          w_pop = 1'b1;
          if (GAP > 0) begin
            w_state_nxt = ST_GAP;
            w_gap_nxt   = GAP_L;
          end
        end
      end
      ST_GAP: begin
        w_gap_nxt = r_gap_cnt - 1'b1;
        if (r_gap_cnt <= GW'(1))
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered echo outputs; data holds until the next strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_stb  <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_tx_stb <= w_pop;
      if (w_pop)
        r_tx_data <= w_out_data;
    end
  end

  // Strobe is masked while reset is asserted so no echo leaves in a reset cycle.
  assign bus.tx_stb_o   = r_tx_stb && !rst_i;
  assign bus.tx_data_o  = r_tx_data;
  assign bus.count_o    = r_count;
  assign bus.overflow_o = r_overflow;

endmodule
